// File: rtl/rv32i_types.sv
// rv32i_types: shared ALU/branch op encodings and the ALU reservation-station entry layout.
package rv32i_types;
  localparam int TAG_W = 5;
  typedef enum logic [2:0] {
    alu_add = 3'b000, alu_sll = 3'b001, alu_sra = 3'b010, alu_sub = 3'b011,
    alu_xor = 3'b100, alu_srl = 3'b101, alu_or = 3'b110, alu_and = 3'b111
  } alu_ops;
  typedef enum logic [2:0] {
    beq = 3'b000, bne = 3'b001, blt = 3'b100, bge = 3'b101, bltu = 3'b110, bgeu = 3'b111
  } branch_funct3_t;
  typedef struct packed {
    logic rdy;
    logic [TAG_W-1:0] tag;
    logic [31:0] val;
  } rs_src_t;
  typedef struct packed {
    logic valid;
    logic aluc;
    logic [2:0] aluop;
    rs_src_t src1;
    rs_src_t src2;
    logic [TAG_W-1:0] dest_tag;
  } alu_rs_entry_t;
  // a waiting source captures the CDB value when its producer tag is broadcast
  function automatic rs_src_t rs_wake(rs_src_t s, logic v, logic [TAG_W-1:0] t, logic [31:0] val);
    rs_src_t w;
    w = s;
    if (v && !s.rdy && s.tag == t) begin
      w.rdy = 1'b1;
      w.val = val;
    end
    return w;
  endfunction
endpackage

// File: rtl/alu_rs_select.sv
// alu_rs_select: lowest-index priority picker returning a one-hot grant.
module alu_rs_select #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0] req,
  output logic             found,
  output logic [DEPTH-1:0] grant
);
  assign found = |req;
  assign grant = req & (~req + DEPTH'(1));
endmodule

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: ALU reservation station with CDB wakeup and a registered issue port.
module alu_issue_queue import rv32i_types::*; #(
  parameter int DEPTH = 4,
  parameter int TAG_W = rv32i_types::TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic             disp_aluc,
  input  logic [2:0]       disp_aluop,
  input  logic             disp_src1_rdy,
  input  logic             disp_src2_rdy,
  input  logic [TAG_W-1:0] disp_src1_tag,
  input  logic [TAG_W-1:0] disp_src2_tag,
  input  logic [31:0]      disp_src1_val,
  input  logic [31:0]      disp_src2_val,
  input  logic [TAG_W-1:0] disp_dest_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  output logic             iss_valid,
  input  logic             iss_ready,
  output logic             iss_aluc,
  output logic [2:0]       iss_aluop,
  output logic [31:0]      iss_a,
  output logic [31:0]      iss_b,
  output logic [TAG_W-1:0] iss_dest_tag
);
  alu_rs_entry_t ent [DEPTH];
  alu_rs_entry_t new_ent;
  logic [DEPTH-1:0] free_v, elig_v, free_g, elig_g;
  logic free_f, elig_f, fire, load;
  logic sel_aluc;
  logic [2:0] sel_aluop;
  logic [31:0] sel_a, sel_b;
  logic [TAG_W-1:0] sel_dest;
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      free_v[i] = !ent[i].valid;
      elig_v[i] = ent[i].valid && ent[i].src1.rdy && ent[i].src2.rdy;
    end
  end
  alu_rs_select #(.DEPTH(DEPTH)) u_free (.req(free_v), .found(free_f), .grant(free_g));
  alu_rs_select #(.DEPTH(DEPTH)) u_elig (.req(elig_v), .found(elig_f), .grant(elig_g));
  assign disp_ready = free_f;
  assign fire = disp_valid && free_f;
  assign load = (!iss_valid || iss_ready) && elig_f;
  always_comb begin
    new_ent.valid = 1'b1;
    new_ent.aluc = disp_aluc;
    new_ent.aluop = disp_aluop;
    new_ent.src1 = rs_wake('{disp_src1_rdy, disp_src1_tag, disp_src1_val}, cdb_valid, cdb_tag, cdb_value);
    new_ent.src2 = rs_wake('{disp_src2_rdy, disp_src2_tag, disp_src2_val}, cdb_valid, cdb_tag, cdb_value);
    new_ent.dest_tag = disp_dest_tag;
  end
  always_comb begin
    sel_aluc = 1'b0;
    sel_aluop = '0;
    sel_a = '0;
    sel_b = '0;
    sel_dest = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (elig_g[i]) begin
        sel_aluc = ent[i].aluc;
        sel_aluop = ent[i].aluop;
        sel_a = ent[i].src1.val;
        sel_b = ent[i].src2.val;
        sel_dest = ent[i].dest_tag;
      end
    end
  end
  // dispatch only targets free slots, so it never collides with the slot being issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      iss_valid <= 1'b0;
      iss_aluc <= 1'b0;
      iss_aluop <= '0;
      iss_a <= '0;
      iss_b <= '0;
      iss_dest_tag <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
      iss_valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (fire && free_g[i]) ent[i] <= new_ent;
        else begin
          ent[i].src1 <= rs_wake(ent[i].src1, cdb_valid, cdb_tag, cdb_value);
          ent[i].src2 <= rs_wake(ent[i].src2, cdb_valid, cdb_tag, cdb_value);
          if (load && elig_g[i]) ent[i].valid <= 1'b0;
        end
      end
      if (load) begin
        iss_valid <= 1'b1;
        iss_aluc <= sel_aluc;
        iss_aluop <= sel_aluop;
        iss_a <= sel_a;
        iss_b <= sel_b;
        iss_dest_tag <= sel_dest;
      end else if (iss_ready) iss_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: scenario tasks plus an issue-port scoreboard for alu_issue_queue.
module tb_alu_issue_queue;
  import rv32i_types::*;
  typedef struct packed {
    logic aluc;
    logic [2:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0] d;
  } exp_t;
  logic clk, rst_n, flush, disp_valid, disp_ready, disp_aluc;
  logic [2:0] disp_aluop;
  logic disp_src1_rdy, disp_src2_rdy;
  logic [4:0] disp_src1_tag, disp_src2_tag, disp_dest_tag, cdb_tag, iss_dest_tag;
  logic [31:0] disp_src1_val, disp_src2_val, cdb_value, iss_a, iss_b;
  logic cdb_valid, iss_valid, iss_ready, iss_aluc;
  logic [2:0] iss_aluop;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  alu_issue_queue #(.DEPTH(4), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_aluc(disp_aluc), .disp_aluop(disp_aluop),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
    .disp_src1_val(disp_src1_val), .disp_src2_val(disp_src2_val), .disp_dest_tag(disp_dest_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_aluc(iss_aluc), .iss_aluop(iss_aluop),
    .iss_a(iss_a), .iss_b(iss_b), .iss_dest_tag(iss_dest_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // every accepted issue must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && iss_valid && iss_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_issue got a=%h b=%h dest=%0d", iss_a, iss_b, iss_dest_tag);
      end else begin
        e = sb.pop_front();
        if ({iss_aluc, iss_aluop, iss_a, iss_b, iss_dest_tag} !== e) begin
          failures++;
          $display("FAIL scoreboard got aluc=%b op=%0d a=%h b=%h dest=%0d expected aluc=%b op=%0d a=%h b=%h dest=%0d",
                   iss_aluc, iss_aluop, iss_a, iss_b, iss_dest_tag, e.aluc, e.op, e.a, e.b, e.d);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic c, input logic [2:0] op, input logic r1, input logic [4:0] t1,
                      input logic [31:0] v1, input logic r2, input logic [4:0] t2, input logic [31:0] v2,
                      input logic [4:0] d);
    disp_aluc = c; disp_aluop = op;
    disp_src1_rdy = r1; disp_src1_tag = t1; disp_src1_val = v1;
    disp_src2_rdy = r2; disp_src2_tag = t2; disp_src2_val = v2;
    disp_dest_tag = d; disp_valid = 1'b1;
    tick();
    disp_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; disp_valid = 1'b0; cdb_valid = 1'b0; iss_ready = 1'b0;
    disp_aluc = 1'b0; disp_aluop = '0; disp_src1_rdy = 1'b0; disp_src2_rdy = 1'b0;
    disp_src1_tag = '0; disp_src2_tag = '0; disp_src1_val = '0; disp_src2_val = '0;
    disp_dest_tag = '0; cdb_tag = '0; cdb_value = '0;
    #12;
    checks++;
    if (iss_valid !== 1'b0 || disp_ready !== 1'b1 || iss_a !== 32'd0 || iss_dest_tag !== 5'd0) begin
      failures++;
      $display("FAIL reset_state got iss_valid=%b disp_ready=%b a=%h dest=%0d expected 0 1 0 0",
               iss_valid, disp_ready, iss_a, iss_dest_tag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    iss_ready = 1'b1;
    sb.push_back('{1'b1, alu_add, 32'd5, 32'd7, 5'd3});
    disp(1'b1, alu_add, 1'b1, 5'd0, 32'd5, 1'b1, 5'd0, 32'd7, 5'd3);
    checks++;
    if (iss_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_early got iss_valid=%b expected 0", iss_valid);
    end
    tick();
    checks++;
    if (iss_valid !== 1'b1 || iss_a !== 32'd5 || iss_b !== 32'd7 || disp_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_latency got iss_valid=%b a=%h b=%h disp_ready=%b expected 1 5 7 1",
               iss_valid, iss_a, iss_b, disp_ready);
    end
    tick(); tick();
  endtask

  task automatic test_wakeup;
    sb.push_back('{1'b0, blt, 32'd10, 32'hFFFF_FFF0, 5'd6});
    disp(1'b0, blt, 1'b1, 5'd0, 32'd10, 1'b0, 5'd9, 32'd0, 5'd6);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (iss_valid !== 1'b0) begin
        failures++;
        $display("FAIL wakeup_wait%0d got iss_valid=%b expected 0", i, iss_valid);
      end
      if (i == 0) tick();
    end
    cdb_valid = 1'b1; cdb_tag = 5'd9; cdb_value = 32'hFFFF_FFF0;
    tick();
    cdb_valid = 1'b0;
    checks++;
    if (iss_valid !== 1'b0) begin
      failures++;
      $display("FAIL wakeup_same_cycle got iss_valid=%b expected 0", iss_valid);
    end
    tick();
    checks++;
    if (iss_valid !== 1'b1 || iss_b !== 32'hFFFF_FFF0) begin
      failures++;
      $display("FAIL wakeup_issue got iss_valid=%b b=%h expected 1 fffffff0", iss_valid, iss_b);
    end
    tick(); tick();
  endtask

  task automatic test_bypass;
    sb.push_back('{1'b1, alu_sub, 32'h1234, 32'd2, 5'd7});
    cdb_valid = 1'b1; cdb_tag = 5'd4; cdb_value = 32'h1234;
    disp(1'b1, alu_sub, 1'b0, 5'd4, 32'd0, 1'b1, 5'd0, 32'd2, 5'd7);
    cdb_valid = 1'b0;
    tick();
    checks++;
    if (iss_valid !== 1'b1 || iss_a !== 32'h1234) begin
      failures++;
      $display("FAIL bypass_issue got iss_valid=%b a=%h expected 1 1234", iss_valid, iss_a);
    end
    tick(); tick();
  endtask

  task automatic test_full_drain;
    iss_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sb.push_back('{1'b1, alu_xor, 32'd100 + 32'(k), 32'd200 + 32'(k), 5'(10 + k)});
      disp(1'b1, alu_xor, 1'b1, 5'd0, 32'd100 + 32'(k), 1'b1, 5'd0, 32'd200 + 32'(k), 5'(10 + k));
      if (k == 0) tick();
    end
    checks++;
    if (disp_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_ready got disp_ready=%b expected 0", disp_ready);
    end
    disp_aluop = alu_or; disp_src1_val = 32'hDEAD; disp_dest_tag = 5'd31; disp_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (iss_valid !== 1'b1 || iss_a !== 32'd100 || iss_dest_tag !== 5'd10 || disp_ready !== 1'b0) begin
        failures++;
        $display("FAIL full_hold%0d got iss_valid=%b a=%h dest=%0d disp_ready=%b expected 1 64 10 0",
                 i, iss_valid, iss_a, iss_dest_tag, disp_ready);
      end
    end
    disp_valid = 1'b0;
    iss_ready = 1'b1;
    tick();
    checks++;
    if (disp_ready !== 1'b1 || iss_valid !== 1'b1) begin
      failures++;
      $display("FAIL drain_reopen got disp_ready=%b iss_valid=%b expected 1 1", disp_ready, iss_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (iss_valid !== 1'b1) begin
        failures++;
        $display("FAIL drain_throughput%0d got iss_valid=%b expected 1", i, iss_valid);
      end
    end
    tick(); tick();
    checks++;
    if (iss_valid !== 1'b0 || sb.size() != 0) begin
      failures++;
      $display("FAIL drain_done got iss_valid=%b pending=%0d expected 0 0", iss_valid, sb.size());
    end
  endtask

  task automatic test_flush;
    iss_ready = 1'b0;
    disp(1'b1, alu_add, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd1, 5'd20);
    tick();
    disp(1'b1, alu_add, 1'b0, 5'd11, 32'd0, 1'b1, 5'd0, 32'd2, 5'd21);
    disp(1'b1, alu_add, 1'b0, 5'd12, 32'd0, 1'b1, 5'd0, 32'd3, 5'd22);
    disp(1'b1, alu_add, 1'b1, 5'd0, 32'd4, 1'b0, 5'd13, 32'd0, 5'd23);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (iss_valid !== 1'b0 || disp_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_clear got iss_valid=%b disp_ready=%b expected 0 1", iss_valid, disp_ready);
    end
    iss_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cdb_valid = 1'b1; cdb_tag = 5'(11 + i); cdb_value = 32'h55;
      tick();
    end
    cdb_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (iss_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_no_issue%0d got iss_valid=%b expected 0", i, iss_valid);
      end
    end
  endtask

  task automatic test_async_reset;
    iss_ready = 1'b0;
    disp(1'b1, alu_and, 1'b1, 5'd0, 32'hAAAA, 1'b1, 5'd0, 32'h5555, 5'd9);
    tick();
    checks++;
    if (iss_valid !== 1'b1) begin
      failures++;
      $display("FAIL areset_pre got iss_valid=%b expected 1", iss_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (iss_valid !== 1'b0 || iss_aluc !== 1'b0 || iss_aluop !== 3'd0 || iss_a !== 32'd0 ||
        iss_b !== 32'd0 || iss_dest_tag !== 5'd0 || disp_ready !== 1'b1) begin
      failures++;
      $display("FAIL areset_async got v=%b c=%b op=%0d a=%h b=%h d=%0d rdy=%b expected all 0 and rdy 1",
               iss_valid, iss_aluc, iss_aluop, iss_a, iss_b, iss_dest_tag, disp_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick();
    checks++;
    if (iss_valid !== 1'b0 || sb.size() != 0) begin
      failures++;
      $display("FAIL final_empty got iss_valid=%b pending=%0d expected 0 0", iss_valid, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_bypass();
    test_full_drain();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Reservation station for the integer ALU in the out-of-order core. Holds dispatched ALU and branch-compare micro-ops until both source operands are available. Operands come either from dispatch or from the common data bus (CDB). Each cycle it selects one ready entry and issues it through a registered valid/ready port to the ALU. It is the producer-side end of the ALU's aluc/aluop/a/b interface.

## Interface
- DEPTH, 4, number of entries (power of two, ≥2)
- TAG_W, 5, width of physical-register/ROB tags

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset is asynchronous and active-low
- flush  in  1  synchronous squash of all entries and the issue register
- disp_valid  in  1  dispatch request
- disp_ready  out  1  at least one free entry
- disp_aluc  in  1  1 = arithmetic op, 0 = branch compare
- disp_aluop  in  3  ALU op or branch funct3 (rv32i_types encodings)
- disp_src1_rdy, disp_src2_rdy  in  1 each  operand value already valid
- disp_src1_tag, disp_src2_tag  in  TAG_W each  producer tag when not ready
- disp_src1_val, disp_src2_val  in  32 each  operand value when ready
- disp_dest_tag  in  TAG_W  destination tag
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_value  in  32  broadcast value
- iss_valid  out  1  issue register holds an op
- iss_ready  in  1  ALU stage accepts
- iss_aluc  out  1
- iss_aluop  out  3
- iss_a, iss_b  out  32 each  operands, src1→a, src2→b
- iss_dest_tag  out  TAG_W

## Operation
- Entry fields: valid, aluc, aluop, per source {rdy, tag, val}, dest_tag.
- disp_ready = OR of ~valid over entries. It is a function of registered state only, never of disp_valid.
- Dispatch fires on disp_valid && disp_ready. It writes the lowest-index free entry.
- Dispatch bypass: if cdb_valid, a source has rdy=0, and its tag == cdb_tag in the same cycle, that source is written with rdy=1 and val=cdb_value.
- Wakeup: each valid entry compares both not-ready sources against the CDB every cycle. On a match it sets rdy and captures cdb_value. If both sources match, both capture.
- An entry is eligible when valid && src1.rdy && src2.rdy, using registered state. An entry woken this cycle is eligible next cycle.
- Select: fixed priority, lowest eligible index.
- Issue register load condition: (!iss_valid || iss_ready) && an eligible entry exists.
  - On load, the issue register takes the entry's fields and the entry's valid clears on the same edge.
  - When there is no eligible entry and iss_ready is asserted, iss_valid drops to 0.
- A freed slot is visible in disp_ready the following cycle. Dispatch never targets a slot being freed in the same cycle.
- flush has highest priority. At the next edge all entry valids and iss_valid become 0. Dispatch, wakeup and issue in that cycle are discarded.
- Tags have no reserved value. Matching is pure equality, gated by rdy=0 and cdb_valid.

## Timing
- Reset (async assert, sync-safe deassert):
  - all entry valid = 0, iss_valid = 0
  - iss_aluc/iss_aluop/iss_a/iss_b/iss_dest_tag = 0
  - disp_ready = 1 during and after reset
- Minimum latency: dispatch at edge t with both operands ready → entry valid after t → selected and loaded at edge t+1 → iss_valid high in cycle t+1..t+2. That is 2 cycles from dispatch to issue.
- CDB wakeup at edge t → eligible in cycle t+1 → iss_valid after edge t+1.
- Issue handshake: while iss_valid && !iss_ready, all iss_* outputs hold stable and no new entry is loaded.
- Throughput: one issue per cycle when iss_ready is held high and entries are eligible.
- Full: with DEPTH valid entries, disp_ready = 0. The first issue load reasserts disp_ready one cycle later.
- Simultaneous dispatch and issue in one cycle are independent. Simultaneous dispatch bypass and wakeup of stored entries by the same CDB tag all capture.

## Structure
- rv32i_types supplies the ALU/branch op encodings (alu_add…alu_and, beq…bgeu).
- Add alu_rs_entry_t (packed struct of the entry fields) to rv32i_types, parameterised by a package-level TAG_W constant matching this block's default.
- Sub-module alu_rs_select: DEPTH-wide lowest-index priority picker. It returns found and a one-hot grant, and is reused for both free-slot and eligible-entry selection.
- No other sub-modules. The ALU itself stays outside and connects directly to the iss_* outputs.

## Test plan
- Reset then dispatch add, src1=5 ready, src2=7 ready, dest 3, with iss_ready=1 → iss_valid two cycles later, aluc=1, aluop=alu_add, a=5, b=7, dest=3; disp_ready stays 1.
- Dispatch blt with src2 waiting on tag 9; CDB tag 9 value 0xFFFF_FFF0 two cycles later → no issue before the wakeup; issue the cycle after with b=0xFFFF_FFF0.
- Dispatch with src1 tag 4 not ready while cdb_valid tag 4 value 0x1234 in the same cycle → entry captured ready; issues with a=0x1234 at minimum latency.
- Fill all DEPTH=4 entries with ready ops and hold iss_ready=0 → disp_ready=0 and iss_* stable for 10 cycles. Raise iss_ready → issues drain in index order 0,1,2,3, one per cycle.
- Three pending entries plus an occupied issue register, flush asserted one cycle → next cycle iss_valid=0, disp_ready=1, and no later issue even when matching CDB tags arrive.
- Assert rst_n low mid-stream with iss_valid=1 → iss_valid and all iss_* outputs drop to 0 immediately, without waiting for a clock edge.
